// File: rtl/anomaly_pkg.sv
// Shared definitions for the anomaly-detection datapath (isolation-tree core,
// sensor input buffer, result buffer).
// A result record is {anomaly, score}: the score sits in the low bits and the
// anomaly flag is the single bit directly above it.
package anomaly_pkg;

   localparam int DEF_SCORE_W = 8;

   // Width of a packed result record for a given score width.
   function automatic int rec_width(input int score_w);
      return score_w + 1;
   endfunction

   // Bit position of the anomaly flag inside a packed result record.
   function automatic int anomaly_bit(input int score_w);
      return score_w;
   endfunction

endpackage

// File: rtl/anomaly_result_buffer_if.sv
// Result-in / result-out handshake bundle for anomaly_result_buffer.
//   result_valid/result_score/result_anomaly : one-cycle result strobe from the tree
//   out_valid/out_ready/out_score/out_anomaly: valid/ready stream to the consumer
// master = producer + consumer side (drives results and out_ready),
// slave  = the buffer itself.
interface anomaly_result_buffer_if
   import anomaly_pkg::*;
#(
   parameter int SCORE_W = DEF_SCORE_W
);
   logic               result_valid;
   logic [SCORE_W-1:0] result_score;
   logic               result_anomaly;
   logic               out_ready;
   logic               out_valid;
   logic [SCORE_W-1:0] out_score;
   logic               out_anomaly;

   modport master (
      output result_valid, result_score, result_anomaly, out_ready,
      input  out_valid, out_score, out_anomaly
   );

   modport slave (
      input  result_valid, result_score, result_anomaly, out_ready,
      output out_valid, out_score, out_anomaly
   );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Pointer/occupancy control for a circular FIFO of DEPTH (power of two) entries.
// Ports: clk, reset (async, active low), push_req/pop_req (raw requests),
// push_en/pop_en (qualified), wr_ptr/rd_ptr, count (0..DEPTH), full, empty.
// A push is accepted when full only if a pop happens in the same cycle.
module sync_fifo_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_req,
   input  logic                     pop_req,
   output logic                     push_en,
   output logic                     pop_en,
   output logic [$clog2(DEPTH)-1:0] wr_ptr,
   output logic [$clog2(DEPTH)-1:0] rd_ptr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == CW'(DEPTH));
      pop_en   = pop_req && !empty;
      push_en  = push_req && (!full || pop_en);
      wr_ptr_d = push_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_en  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_ptr = wr_ptr_q;
   assign rd_ptr = rd_ptr_q;
   assign count  = count_q;
endmodule

// File: rtl/anomaly_result_buffer.sv
// Buffers isolation-tree results ({anomaly, score}) in a small circular FIFO
// and presents them to a downstream consumer over valid/ready.
// Ports: clk, reset (async, active low), bus (slave: result strobe in,
// out stream), clear_status (sync clear of overflow/drop_count), fifo_count,
// fifo_full, fifo_empty, overflow (sticky), drop_count (saturating).
// Results arriving while full with no simultaneous pop are dropped and counted.
module anomaly_result_buffer
   import anomaly_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int SCORE_W = DEF_SCORE_W,
   parameter int CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   anomaly_result_buffer_if.slave bus,
   input  logic                   clear_status,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   fifo_full,
   output logic                   fifo_empty,
   output logic                   overflow,
   output logic [CNT_W-1:0]       drop_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int REC_W = rec_width(SCORE_W);
   localparam int A_BIT = anomaly_bit(SCORE_W);

   logic             push_en, pop_en, drop;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [REC_W-1:0] wr_rec_d, head_rec;
   logic [REC_W-1:0] mem_q [DEPTH];
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] drop_count_q, drop_count_d;

   sync_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk      (clk),
      .reset    (reset),
      .push_req (bus.result_valid),
      .pop_req  (bus.out_ready),
      .push_en  (push_en),
      .pop_en   (pop_en),
      .wr_ptr   (wr_ptr),
      .rd_ptr   (rd_ptr),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      wr_rec_d = {bus.result_anomaly, bus.result_score};
      drop     = bus.result_valid && !push_en;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      // clear has priority over a drop in the same cycle
      if (clear_status) begin
         overflow_d   = 1'b0;
         drop_count_d = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_W'(1);
      end
   end

   // Storage needs no reset: output is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr] <= wr_rec_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   always_comb begin
      head_rec        = fifo_empty ? '0 : mem_q[rd_ptr];
      bus.out_valid   = !fifo_empty;
      bus.out_score   = head_rec[SCORE_W-1:0];
      bus.out_anomaly = head_rec[A_BIT];
   end

   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;
endmodule

// File: doc/anomaly_result_buffer.md
Name: anomaly_result_buffer

Overview:
- Output-side counterpart to the sensor input buffer: captures per-sample isolation-tree results (path-length score plus anomaly flag) and presents them to a downstream consumer over a valid/ready handshake.
- Small circular FIFO decouples the tree's result pulse from the consumer's back-pressure.
- Drops and counts results when full; status flags for the host.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- SCORE_W, 8, width of the path-length score.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (clears all state immediately when low).
- result_valid  input  1  one-cycle strobe: result_score/result_anomaly are valid this cycle.
- result_score  input  SCORE_W  path-length score for the sample.
- result_anomaly  input  1  1 = sample classified anomalous.
- clear_status  input  1  synchronous clear of overflow and drop_count.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_valid  output  1  head entry available.
- out_score  output  SCORE_W  head entry score.
- out_anomaly  output  1  head entry flag.
- fifo_count  output  log2(DEPTH)+1  occupied entries, 0..DEPTH.
- fifo_full  output  1  fifo_count == DEPTH.
- fifo_empty  output  1  fifo_count == 0.
- overflow  output  1  sticky: at least one result dropped.
- drop_count  output  CNT_W  number of dropped results, saturating at all-ones.

Behaviour:
- Reset (reset low, async): write/read pointers 0, fifo_count 0, fifo_empty 1, fifo_full 0, out_valid 0, overflow 0, drop_count 0. Storage contents are don't-care, but out_score and out_anomaly read 0 while empty.
- Push: result_valid=1 and (not full, or a pop occurs in the same cycle) → entry {anomaly, score} written at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: out_valid=1 and out_ready=1 → rd_ptr increments modulo DEPTH.
- out_valid = !fifo_empty. out_score/out_anomaly are driven from storage at rd_ptr; they are held while out_valid=1 and out_ready=0.
- Latency: a push at edge N into an empty FIFO gives out_valid=1 with that data after edge N, i.e. visible in cycle N+1. No combinational path from result_* to out_*.
- Simultaneous push and pop:
  - Count is unchanged.
  - Allowed when full: the push is accepted, with no drop.
  - Allowed when the FIFO holds 1 entry: the new entry becomes the head next cycle.
- Push while full without pop:
  - Result discarded; storage and pointers unchanged.
  - overflow set to 1 at the next edge.
  - drop_count increments by 1, saturating at 2^CNT_W−1.
- out_ready while empty: ignored, no pointer change.
- clear_status=1:
  - overflow and drop_count go to 0 at the next edge.
  - If a drop occurs in the same cycle, clear wins: both end at 0.
  - FIFO contents are unaffected.
- Pointer wrap: pointers are log2(DEPTH) bits, and wrap is natural. fifo_count is a separate up/down counter: +1 on push-only, −1 on pop-only.
- Reset asserted mid-operation: all pending entries are lost, and out_valid drops immediately (asynchronously).
- Ordering: strict FIFO; the entry order out equals the accepted order in.

Decomposition:
- Shared package (anomaly_pkg): SCORE_W default, a result-record width constant (SCORE_W+1), and the bit position of the anomaly flag within the record, shared with the isolation-tree core and the input buffer.
- One natural sub-module: sync_fifo_ctrl. It holds the pointers, count, full/empty and push/pop qualification. The top adds storage packing, the drop/overflow logic and status clear.

Test Plan (DEPTH=4, SCORE_W=8):
- Reset and single result: after reset release, push score=0x2A, anomaly=1, with out_ready=0. Next cycle: out_valid=1, out_score=0x2A, out_anomaly=1, fifo_count=1. Then out_ready=1 for 1 cycle → fifo_empty=1, out_valid=0.
- Fill and overflow: push 0x01..0x05 on consecutive cycles with out_ready=0. Result: fifo_full=1, fifo_count=4, overflow=1, drop_count=1. Draining gives 0x01, 0x02, 0x03, 0x04 in order; 0x05 never appears.
- Full with simultaneous push/pop: with the FIFO full of 0x10..0x13, push 0x14 with out_ready=1 in the same cycle. Result: drop_count unchanged, fifo_count=4, and the drain order is 0x11, 0x12, 0x13, 0x14.
- Back-pressure hold and wrap-around: push 12 results, toggling out_ready randomly. Every entry is received exactly once in order; out_score stays stable while out_valid=1 and out_ready=0; the pointers wrap 3 times.
- Saturation and clear: with CNT_W=8, force 300 drops → drop_count=0xFF. Then assert clear_status in the same cycle as a further drop → overflow=0, drop_count=0.
- Async reset mid-stream: with 3 entries queued, pull reset low between edges → out_valid=0 and fifo_count=0 immediately. After release, a new push 0x77 is the first output.
